// File: rtl/cla_pipe_adder.sv
// cla_pipe_adder: two-stage valid/ready adder/subtractor using two-level carry lookahead
module cla_pipe_adder #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             neg
);
  localparam int NG = WIDTH / 4;
  localparam int LV = $clog2(NG + 1);
  function automatic logic [4:0] cla4(input logic [3:0] g, input logic [3:0] p, input logic ci);
    cla4[0] = ci;
    cla4[1] = g[0] | (p[0] & ci);
    cla4[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    cla4[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | ((&p[2:0]) & ci);
    cla4[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | ((&p[3:1]) & g[0]) | ((&p) & ci);
  endfunction
  logic                  accept, s1_adv, s2_adv;
  logic                  s1_valid_q, s1_valid_d, out_valid_q, out_valid_d;
  logic [WIDTH-1:0]      p_q, p_d;
  logic [NG-1:0][2:0]    g_q, g_d;
  logic                  c0_q, c0_d;
  logic [NG-1:0]         pg_q, pg_d, gg_q, gg_d;
  logic [WIDTH-1:0]      s_q, s_d;
  logic                  cout_q, cout_d, ovf_q, ovf_d, zero_q, zero_d, neg_q, neg_d;
  logic [WIDTH-1:0]      bx, pn, gn, sn;
  logic [WIDTH:0]        c;
  logic [4:0]            t;
  logic                  lg [0:LV][0:NG];
  logic                  lp [0:LV][0:NG];
  assign s2_adv    = !out_valid_q | out_ready;
  assign s1_adv    = s1_valid_q & s2_adv;
  assign in_ready  = !s1_valid_q | s2_adv;
  assign accept    = in_valid & in_ready;
  assign out_valid = out_valid_q;
  assign S         = s_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;
  assign neg       = neg_q;
  always_comb begin
    bx = B ^ {WIDTH{sub}};
    pn = A ^ bx;
    gn = A & bx;
    p_d = accept ? pn : p_q;
    c0_d = accept ? sub : c0_q;
    g_d = g_q;
    pg_d = pg_q;
    gg_d = gg_q;
    t = '0;
    for (int k = 0; k < NG; k++) begin
      t = cla4(gn[4*k +: 4], pn[4*k +: 4], 1'b0);
      g_d[k] = accept ? gn[4*k +: 3] : g_q[k];
      pg_d[k] = accept ? &pn[4*k +: 4] : pg_q[k];
      gg_d[k] = accept ? t[4] : gg_q[k];
    end
    s1_valid_d = accept | (s1_valid_q & !s1_adv);
    lg = '{default: '{default: 1'b0}};
    lp = '{default: '{default: 1'b0}};
    lg[0][0] = c0_q;
    for (int k = 0; k < NG; k++) begin
      lg[0][k+1] = gg_q[k];
      lp[0][k+1] = pg_q[k];
    end
    for (int l = 0; l < LV; l++) begin
      for (int i = 0; i <= NG; i++) begin
        if (i < (1 << l)) begin
          lg[l+1][i] = lg[l][i];
          lp[l+1][i] = lp[l][i];
        end else begin
          lg[l+1][i] = lg[l][i] | (lp[l][i] & lg[l][i - (1 << l)]);
          lp[l+1][i] = lp[l][i] & lp[l][i - (1 << l)];
        end
      end
    end
    c = '0;
    for (int k = 0; k < NG; k++) begin
      t = cla4({1'b0, g_q[k]}, p_q[4*k +: 4], lg[LV][k]);
      c[4*k +: 4] = t[3:0];
    end
    c[WIDTH] = lg[LV][NG];
    sn = p_q ^ c[WIDTH-1:0];
    s_d = s1_adv ? sn : s_q;
    cout_d = s1_adv ? c[WIDTH] : cout_q;
    ovf_d = s1_adv ? c[WIDTH] ^ c[WIDTH-1] : ovf_q;
    zero_d = s1_adv ? ~|sn : zero_q;
    neg_d = s1_adv ? sn[WIDTH-1] : neg_q;
    out_valid_d = s2_adv ? s1_valid_q : out_valid_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      out_valid_q <= 1'b0;
      p_q <= '0;
      g_q <= '0;
      c0_q <= 1'b0;
      pg_q <= '0;
      gg_q <= '0;
      s_q <= '0;
      cout_q <= 1'b0;
      ovf_q <= 1'b0;
      zero_q <= 1'b0;
      neg_q <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      out_valid_q <= out_valid_d;
      p_q <= p_d;
      g_q <= g_d;
      c0_q <= c0_d;
      pg_q <= pg_d;
      gg_q <= gg_d;
      s_q <= s_d;
      cout_q <= cout_d;
      ovf_q <= ovf_d;
      zero_q <= zero_d;
      neg_q <= neg_d;
    end
  end
endmodule

// File: tb/tb_cla_pipe_adder.sv
// tb_cla_pipe_adder: directed vectors, stall/reset sequences and random streams vs an arithmetic model
module tb_cla_pipe_adder;
  localparam int W = 32;
  typedef struct packed {
    logic [W-1:0] s;
    logic         cout;
    logic         ovf;
    logic         zero;
    logic         neg;
  } res_t;
  typedef struct {
    string        name;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    res_t         exp;
  } vec_t;
  logic         clk, rst_n, in_valid, in_ready, sub, out_valid, out_ready;
  logic [W-1:0] A, B, S;
  logic         cout, ovf, zero, neg;
  res_t         got;
  int           tests, fails, occ;
  res_t         q[$];
  bit           stall;
  res_t         held;
  cla_pipe_adder #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .S(S), .cout(cout), .ovf(ovf), .zero(zero), .neg(neg)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  assign got = {S, cout, ovf, zero, neg};
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sb);
    res_t r;
    logic [W:0] wide;
    if (sb) begin
      r.s = a - b;
      r.cout = a >= b;
      r.ovf = (a[W-1] != b[W-1]) && (r.s[W-1] != a[W-1]);
    end else begin
      wide = {1'b0, a} + {1'b0, b};
      r.s = wide[W-1:0];
      r.cout = wide[W];
      r.ovf = (a[W-1] == b[W-1]) && (r.s[W-1] != a[W-1]);
    end
    r.zero = r.s == '0;
    r.neg = r.s[W-1];
    return r;
  endfunction
  function automatic logic [W-1:0] rnd();
    logic [63:0] x;
    case ($urandom_range(0, 5))
      0: x = '0;
      1: x = '1;
      2: x = 64'(1) << (W - 1);
      3: x = 64'(1);
      default: x = {$urandom, $urandom};
    endcase
    return x[W-1:0];
  endfunction
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      occ = 0;
      stall = 0;
    end else begin
      bit acc, del;
      res_t e;
      acc = in_valid && in_ready;
      del = out_valid && out_ready;
      chk("in_ready", in_ready, !(occ == 2 && !out_ready));
      if (stall) chk("hold", got, held);
      if (del) begin
        if (q.size() == 0) chk("spurious_out_valid", 1, 0);
        else begin
          e = q.pop_front();
          chk("stream_result", got, e);
        end
      end
      if (acc) q.push_back(model(A, B, sub));
      occ = occ + int'(acc) - int'(del);
      stall = out_valid && !out_ready;
      held = got;
    end
  end
  task automatic run_stream(input int n, input bit always_ready);
    int sent, cyc;
    bit acc;
    logic [W-1:0] pa, pb;
    logic ps;
    sent = 0;
    cyc = 0;
    pa = rnd();
    pb = rnd();
    ps = 1'($urandom_range(0, 1));
    while (sent < n && cyc < 20 * n + 100) begin
      out_ready = always_ready ? 1'b1 : 1'($urandom_range(0, 1));
      A = pa;
      B = pb;
      sub = ps;
      in_valid = 1'b1;
      #1 acc = in_ready;
      @(posedge clk);
      #1;
      cyc++;
      if (acc) begin
        sent++;
        pa = rnd();
        pb = rnd();
        ps = 1'($urandom_range(0, 1));
      end
    end
    chk("stream_sent", sent, n);
    if (always_ready) chk("throughput_cycles", cyc, n);
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 10 && q.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    chk("drain", q.size(), 0);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    vec_t v[6];
    v[0] = '{"add_5_3",      32'h0000_0005, 32'h0000_0003, 1'b0, '{32'h0000_0008, 1'b0, 1'b0, 1'b0, 1'b0}};
    v[1] = '{"full_carry",   32'hFFFF_FFFF, 32'h0000_0001, 1'b0, '{32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0}};
    v[2] = '{"signed_ovf",   32'h7FFF_FFFF, 32'h0000_0001, 1'b0, '{32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1}};
    v[3] = '{"sub_3_5",      32'h0000_0003, 32'h0000_0005, 1'b1, '{32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b1}};
    v[4] = '{"sub_ovf",      32'h8000_0000, 32'h0000_0001, 1'b1, '{32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0}};
    v[5] = '{"sub_equal",    32'h1234_5678, 32'h1234_5678, 1'b1, '{32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0}};
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    A = '0;
    B = '0;
    sub = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_outputs", got, 0);
    chk("rst_in_ready", in_ready, 1);
    rst_n = 1'b1;
    foreach (v[i]) begin
      A = v[i].a;
      B = v[i].b;
      sub = v[i].sub;
      in_valid = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      chk({v[i].name, "_lat1"}, out_valid, 0);
      @(posedge clk);
      #1;
      chk({v[i].name, "_lat2"}, out_valid, 1);
      chk(v[i].name, got, v[i].exp);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b0;
    A = 32'd1;
    B = 32'd1;
    sub = 1'b0;
    in_valid = 1'b1;
    #1 chk("stall_ready0", in_ready, 1);
    @(posedge clk);
    #1 A = 32'd2;
    B = 32'd2;
    chk("stall_ready1", in_ready, 1);
    @(posedge clk);
    #1 A = 32'd3;
    B = 32'd3;
    chk("stall_full", in_ready, 0);
    @(posedge clk);
    #1;
    chk("stall_held_ready", in_ready, 0);
    chk("stall_held_valid", out_valid, 1);
    chk("stall_held_s", S, 32'd2);
    out_ready = 1'b1;
    #1 chk("stall_release_ready", in_ready, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    chk("stall_second_s", S, 32'd4);
    repeat (3) @(posedge clk);
    #1;
    out_ready = 1'b0;
    A = 32'd10;
    B = 32'd20;
    in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1 in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_outputs", got, 0);
    chk("midrst_in_ready", in_ready, 1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1 chk("no_stale", out_valid, 0);
    end
    run_stream(10, 1'b0);
    run_stream(1000, 1'b1);
    run_stream(200, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
